// File: rtl/fc_infer_ctrl.sv
// ---------------------------------------------------------------------------
// fc_infer_ctrl
// Sequencer for the binarized fully-connected classifier stage.
//
// On a start pulse it reads the BEATS-deep feature RAM (one PIX_W-bit beat per
// cycle), forwards each beat to the FC layer, waits for the FC layer's score
// pulse (or aborts after TIMEOUT idle cycles), runs a one-class-per-cycle
// argmax over the captured scores and holds the winner on a valid/ready
// result port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle classify request (honoured in IDLE only)
//   busy                high in every state except IDLE
//   mem_rd_en/addr      feature RAM read strobe and beat address
//   mem_rd_data         feature RAM data, valid the cycle after mem_rd_en
//   fc_valid_in/pixels  beat strobe and pixels towards the FC layer
//   fc_valid_out        FC score-valid pulse
//   fc_scores           flat scores, class k at [k*SCORE_W +: SCORE_W]
//   result_valid/ready  result handshake
//   result_class/score  winning class and score (4'hF / 0 on timeout)
//   err_timeout         result is a timeout abort
// ---------------------------------------------------------------------------
module fc_infer_ctrl #(
  parameter int BEATS       = 25,
  parameter int PIX_W       = 16,
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 9,
  parameter int TIMEOUT     = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           mem_rd_en,
  output logic [4:0]                     mem_rd_addr,
  input  logic [PIX_W-1:0]               mem_rd_data,
  output logic                           fc_valid_in,
  output logic [PIX_W-1:0]               fc_pixels,
  input  logic                           fc_valid_out,
  input  logic [NUM_CLASSES*SCORE_W-1:0] fc_scores,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [3:0]                     result_class,
  output logic [SCORE_W-1:0]             result_score,
  output logic                           err_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]       LAST_BEAT  = 5'(BEATS - 1);
  localparam logic [3:0]       LAST_CLASS = 4'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] LAST_TMO   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_ARGMAX,
    S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           beat_q, beat_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           best_class_q, best_class_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic                 err_q, err_d;
  logic                 fc_valid_in_q, fc_valid_in_d;
  logic                 capture;
  logic [SCORE_W-1:0]   cur_score;
  logic [SCORE_W-1:0]   scores_q [NUM_CLASSES];
  logic [SCORE_W-1:0]   scores_d [NUM_CLASSES];

  // Score bank: loaded only on the accepted fc_valid_out in WAIT, so stray
  // pulses in any other state never disturb the captured values.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_score
      assign scores_d[gi] = capture ? fc_scores[gi*SCORE_W +: SCORE_W] : scores_q[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          scores_q[gi] <= '0;
        end else begin
          scores_q[gi] <= scores_d[gi];
        end
      end
    end
  endgenerate

  // Score under inspection by the argmax walk.
  always_comb begin
    cur_score = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (idx_q == k[3:0]) begin
        cur_score = scores_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      tmo_q         <= '0;
      idx_q         <= '0;
      best_class_q  <= '0;
      best_score_q  <= '0;
      err_q         <= 1'b0;
      fc_valid_in_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      idx_q         <= idx_d;
      best_class_q  <= best_class_d;
      best_score_q  <= best_score_d;
      err_q         <= err_d;
      fc_valid_in_q <= fc_valid_in_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    idx_d         = idx_q;
    best_class_d  = best_class_q;
    best_score_d  = best_score_q;
    err_d         = err_q;
    capture       = 1'b0;
    // RAM data lands one cycle after the read, so the beat strobe is the
    // read strobe delayed by one cycle.
    fc_valid_in_d = (state_q == S_FEED);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          beat_d  = '0;
        end
      end

      S_FEED: begin
        tmo_d = '0;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_WAIT;
        end else begin
          beat_d = beat_q + 5'd1;
        end
      end

      S_WAIT: begin
        if (fc_valid_out) begin
          capture      = 1'b1;
          idx_d        = '0;
          best_class_d = '0;
          best_score_d = '0;
          state_d      = S_ARGMAX;
        end else if (!fc_valid_in_q) begin
          // The first WAIT cycle still carries the last beat; counting
          // starts on the cycle after it.
          if (tmo_q == LAST_TMO) begin
            state_d      = S_HOLD;
            err_d        = 1'b1;
            best_class_d = 4'hF;
            best_score_d = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      S_ARGMAX: begin
        // Strictly-greater update keeps the lowest index on ties.
        if (cur_score > best_score_q) begin
          best_score_d = cur_score;
          best_class_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_CLASS) begin
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (result_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign mem_rd_en    = (state_q == S_FEED);
  assign mem_rd_addr  = beat_q;
  assign fc_valid_in  = fc_valid_in_q;
  assign fc_pixels    = fc_valid_in_q ? mem_rd_data : '0;
  assign result_valid = (state_q == S_HOLD);
  assign result_class = best_class_q;
  assign result_score = best_score_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_fc_infer_ctrl.sv
// Directed testbench for fc_infer_ctrl. Feature RAM model returns
// 16'hA5A5 ^ beat one cycle after each read and 16'hDEAD otherwise.
module tb_fc_infer_ctrl;
  localparam int BEATS   = 25;
  localparam int PIX_W   = 16;
  localparam int NC      = 10;
  localparam int SW      = 9;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              mem_rd_en;
  logic [4:0]        mem_rd_addr;
  logic [PIX_W-1:0]  mem_rd_data;
  logic              fc_valid_in;
  logic [PIX_W-1:0]  fc_pixels;
  logic              fc_valid_out;
  logic [NC*SW-1:0]  fc_scores;
  logic              result_valid;
  logic              result_ready;
  logic [3:0]        result_class;
  logic [SW-1:0]     result_score;
  logic              err_timeout;

  always #5 clk = ~clk;

  fc_infer_ctrl #(
    .BEATS(BEATS), .PIX_W(PIX_W), .NUM_CLASSES(NC), .SCORE_W(SW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .fc_valid_in(fc_valid_in), .fc_pixels(fc_pixels),
    .fc_valid_out(fc_valid_out), .fc_scores(fc_scores),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_score(result_score),
    .err_timeout(err_timeout)
  );

  // Feature RAM model
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? (16'hA5A5 ^ {11'd0, mem_rd_addr}) : 16'hDEAD;
  end

  int pass_cnt = 0;
  int total    = 0;

  typedef int sc_t [NC];

  // Per-frame observations (t = 0 is the cycle after start is sampled)
  int o_first_rd, o_rd, o_addr_err, o_vin, o_pix_err, o_last_vin, o_vout, o_hold, o_busy_err;

  function automatic logic [NC*SW-1:0] pack(input sc_t s);
    logic [NC*SW-1:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[k*SW +: SW] = s[k][SW-1:0];
    return v;
  endfunction

  // Pulses start from a negedge, streams the frame, answers with the scores
  // resp_delay cycles after the last beat (never if negative), optionally
  // injects garbage fc_valid_out pulses in FEED and ARGMAX. Returns at the
  // negedge of the first result_valid cycle (or after a cycle budget).
  task automatic run_frame(input logic [NC*SW-1:0] sc, input int resp_delay, input bit spurious);
    o_first_rd = -1; o_rd = 0; o_addr_err = 0; o_vin = 0; o_pix_err = 0;
    o_last_vin = -1; o_vout = -1; o_hold = -1; o_busy_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 300 && o_hold < 0; t++) begin
      if (!busy) o_busy_err++;
      if (mem_rd_en) begin
        if (o_first_rd < 0) o_first_rd = t;
        if (mem_rd_addr != 5'(o_rd)) o_addr_err++;
        o_rd++;
      end
      if (fc_valid_in) begin
        if (fc_pixels !== (16'hA5A5 ^ 16'(o_vin))) o_pix_err++;
        o_vin++;
        o_last_vin = t;
      end else if (fc_pixels !== '0) begin
        o_pix_err++;
      end
      if (result_valid) begin
        o_hold = t;
      end else begin
        fc_valid_out = 1'b0;
        fc_scores    = '1;
        if (o_vin == BEATS && o_vout < 0 && resp_delay >= 0 && t == o_last_vin + resp_delay) begin
          fc_valid_out = 1'b1;
          fc_scores    = sc;
          o_vout       = t;
        end
        if (spurious && (t == 5 || (o_vout >= 0 && t == o_vout + 3))) begin
          fc_valid_out = 1'b1;
          fc_scores    = '1;
        end
        @(negedge clk);
      end
    end
    fc_valid_out = 1'b0;
    $display("frame: vin=%0d class=%0h score=%0d err=%0b hold_t=%0d", o_vin, result_class, result_score, err_timeout, o_hold);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, mem_rd_en, mem_rd_addr, fc_valid_in, fc_pixels, result_valid, result_class, result_score, err_timeout} !== '0)
      $display("FAIL reset_outputs got busy=%0b rd=%0b addr=%0d vin=%0b pix=%h rv=%0b cls=%0h sc=%0d err=%0b expected all 0",
               busy, mem_rd_en, mem_rd_addr, fc_valid_in, fc_pixels, result_valid, result_class, result_score, err_timeout);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL reset_release_idle got busy=%0b rd=%0b expected 0 0", busy, mem_rd_en);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_feed();
    sc_t s;
    s = '{1, 2, 3, 4, 5, 6, 7, 80, 9, 10};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !(mem_rd_en && mem_rd_addr == 5'd10); i++) @(negedge clk);
    total++;
    if (!(mem_rd_en && mem_rd_addr == 5'd10)) $display("FAIL midfeed_reach_beat10 got addr=%0d rd=%0b expected 10 1", mem_rd_addr, mem_rd_en);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, mem_rd_en, mem_rd_addr, fc_valid_in, fc_pixels, result_valid, result_class, result_score, err_timeout} !== '0)
      $display("FAIL midfeed_reset_outputs got busy=%0b rd=%0b addr=%0d vin=%0b pix=%h expected all 0",
               busy, mem_rd_en, mem_rd_addr, fc_valid_in, fc_pixels);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL midfeed_no_resume got busy=%0b expected 0", busy);
    else pass_cnt++;
    run_frame(pack(s), 2, 1'b0);
    total++;
    if (o_first_rd != 0 || o_addr_err != 0 || o_rd != BEATS)
      $display("FAIL midfeed_restart got first_rd=%0d addr_err=%0d reads=%0d expected 0 0 25", o_first_rd, o_addr_err, o_rd);
    else pass_cnt++;
    total++;
    if (result_class !== 4'd7 || result_score !== 9'd80) $display("FAIL midfeed_result got %0d/%0d expected 7/80", result_class, result_score);
    else pass_cnt++;
    accept();
  endtask

  task automatic test_feed_stream();
    sc_t s;
    s = '{5, 300, 17, 0, 299, 1, 2, 3, 4, 6};
    run_frame(pack(s), 2, 1'b0);
    total++;
    if (o_first_rd != 0) $display("FAIL feed_first_read got t=%0d expected t=0", o_first_rd);
    else pass_cnt++;
    total++;
    if (o_rd != BEATS || o_addr_err != 0) $display("FAIL feed_addresses got reads=%0d addr_err=%0d expected 25 0", o_rd, o_addr_err);
    else pass_cnt++;
    total++;
    if (o_vin != BEATS || o_last_vin != BEATS) $display("FAIL feed_valid_in got pulses=%0d last_t=%0d expected 25 25", o_vin, o_last_vin);
    else pass_cnt++;
    total++;
    if (o_pix_err != 0) $display("FAIL feed_pixels got errors=%0d expected 0", o_pix_err);
    else pass_cnt++;
    total++;
    if (o_busy_err != 0) $display("FAIL feed_busy got low_cycles=%0d expected 0", o_busy_err);
    else pass_cnt++;
    total++;
    if (o_hold - o_vout != 11) $display("FAIL feed_result_latency got %0d expected 11", o_hold - o_vout);
    else pass_cnt++;
    total++;
    if (result_class !== 4'd1 || result_score !== 9'd300 || err_timeout !== 1'b0)
      $display("FAIL feed_result got %0d/%0d err=%0b expected 1/300 err=0", result_class, result_score, err_timeout);
    else pass_cnt++;
    accept();
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0) $display("FAIL feed_transfer_idle got rv=%0b busy=%0b expected 0 0", result_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_argmax();
    sc_t s;
    logic [3:0] ec;
    logic [SW-1:0] es;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin s = '{10, 50, 399, 12, 0, 399, 7, 8, 9, 400}; ec = 4'd9; es = 9'd400; end
        1: begin s = '{3, 399, 399, 0, 0, 0, 0, 0, 0, 0};     ec = 4'd1; es = 9'd399; end
        2: begin s = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};         ec = 4'd0; es = 9'd7;   end
        3: begin s = '{400, 0, 0, 401, 0, 511, 0, 0, 0, 0};   ec = 4'd5; es = 9'd511; end
        default: begin s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  ec = 4'd0; es = 9'd0;   end
      endcase
      run_frame(pack(s), i, 1'b0);
      total++;
      if (result_class !== ec || result_score !== es || err_timeout !== 1'b0)
        $display("FAIL argmax_vec%0d got %0d/%0d err=%0b expected %0d/%0d err=0", i, result_class, result_score, err_timeout, ec, es);
      else pass_cnt++;
      accept();
    end
  endtask

  task automatic test_timeout();
    sc_t s;
    s = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
    run_frame(pack(s), -1, 1'b0);
    total++;
    if (o_hold - o_last_vin != TIMEOUT + 1) $display("FAIL timeout_latency got %0d expected %0d", o_hold - o_last_vin, TIMEOUT + 1);
    else pass_cnt++;
    total++;
    if (result_valid !== 1'b1 || err_timeout !== 1'b1 || result_class !== 4'hF || result_score !== 9'd0)
      $display("FAIL timeout_result got rv=%0b err=%0b cls=%0h sc=%0d expected 1 1 f 0", result_valid, err_timeout, result_class, result_score);
    else pass_cnt++;
    accept();
    total++;
    if (err_timeout !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL timeout_clear got err=%0b rv=%0b busy=%0b expected 0 0 0", err_timeout, result_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_hold_stall();
    sc_t s;
    int unstable;
    s = '{1, 2, 123, 4, 5, 6, 7, 8, 9, 10};
    run_frame(pack(s), 1, 1'b0);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5 || i == 12);
      @(negedge clk);
      if (result_valid !== 1'b1 || busy !== 1'b1 || result_class !== 4'd2 || result_score !== 9'd123 || err_timeout !== 1'b0)
        unstable++;
    end
    start = 1'b0;
    total++;
    if (unstable != 0) $display("FAIL hold_stable got unstable_cycles=%0d expected 0", unstable);
    else pass_cnt++;
    accept();
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL hold_transfer_idle got busy=%0b rv=%0b expected 0 0", busy, result_valid);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL hold_start_not_queued got busy=%0b rd=%0b expected 0 0", busy, mem_rd_en);
    else pass_cnt++;
    s = '{0, 0, 0, 0, 0, 0, 0, 0, 44, 0};
    run_frame(pack(s), 2, 1'b0);
    total++;
    if (o_vin != BEATS || result_class !== 4'd8 || result_score !== 9'd44)
      $display("FAIL hold_second_frame got vin=%0d %0d/%0d expected 25 8/44", o_vin, result_class, result_score);
    else pass_cnt++;
    accept();
  endtask

  task automatic test_back_to_back();
    sc_t s;
    s = '{0, 0, 0, 200, 0, 0, 0, 0, 0, 0};
    run_frame(pack(s), 0, 1'b0);
    accept();
    // start driven in the very first IDLE cycle after the transfer
    s = '{0, 0, 0, 0, 150, 0, 0, 0, 0, 0};
    run_frame(pack(s), 3, 1'b0);
    total++;
    if (o_first_rd != 0 || o_vin != BEATS) $display("FAIL b2b_accept got first_rd=%0d vin=%0d expected 0 25", o_first_rd, o_vin);
    else pass_cnt++;
    total++;
    if (result_class !== 4'd4 || result_score !== 9'd150) $display("FAIL b2b_result got %0d/%0d expected 4/150", result_class, result_score);
    else pass_cnt++;
    accept();
  endtask

  task automatic test_spurious();
    sc_t s;
    s = '{0, 0, 0, 0, 0, 0, 255, 0, 0, 0};
    run_frame(pack(s), 2, 1'b1);
    total++;
    if (o_vin != BEATS || o_addr_err != 0 || o_hold - o_vout != 11)
      $display("FAIL spurious_flow got vin=%0d addr_err=%0d lat=%0d expected 25 0 11", o_vin, o_addr_err, o_hold - o_vout);
    else pass_cnt++;
    total++;
    if (result_class !== 4'd6 || result_score !== 9'd255 || err_timeout !== 1'b0)
      $display("FAIL spurious_result got %0d/%0d err=%0b expected 6/255 err=0", result_class, result_score, err_timeout);
    else pass_cnt++;
    accept();
  endtask

  initial begin
    start        = 1'b0;
    fc_valid_out = 1'b0;
    fc_scores    = '0;
    result_ready = 1'b0;
    test_reset();
    test_reset_mid_feed();
    test_feed_stream();
    test_argmax();
    test_timeout();
    test_hold_stall();
    test_back_to_back();
    test_spurious();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary, passed=%0d total=%0d", pass_cnt, total);
    $fatal(1);
  end

endmodule
